spi_word_tx: RTL and testbench
==============================

SPI_WORD_TX -- requirements
Module: spi_word_tx

Interface
REQ-001 Parameter DIV, default 4, meaning: SCL half-period in clk cycles; legal range 2..255.
REQ-002 Parameter GAP, default 4, meaning: idle clk cycles between frames, with CS low; legal range 1..255.
REQ-003 Parameter DEPTH, default 4, meaning: input FIFO depth in words; power of two, 2..16.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 resetq  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  16  word to transmit, MSB first.
REQ-007 in_valid  input  1  in_data is offered this cycle.
REQ-008 in_ready  output  1  FIFO can accept a word; equals not-full.
REQ-009 CS  output  1  frame select, active-high, registered.
REQ-010 SCL  output  1  serial clock, idle low, registered.
REQ-011 MOSI  output  1  serial data, registered; changes only while SCL is low.
REQ-012 busy  output  1  high from the first cycle CS is high through the last GAP cycle.

Function
REQ-013 A word SHALL be accepted on a clk edge where in_valid and in_ready are both high; accepted words SHALL be transmitted in acceptance order.
REQ-014 in_ready SHALL reflect FIFO occupancy before the edge, so a push while full SHALL be dropped even if a pop occurs on the same edge.
REQ-015 A push and a pop on the same edge while not full SHALL leave occupancy unchanged; FIFO pointers SHALL wrap modulo DEPTH.
REQ-016 States SHALL be IDLE, SETUP, SHIFT, TRAIL and GAPW.
REQ-017 IDLE with FIFO non-empty: pop the word into a 16-bit shift register, set CS=1, set MOSI=bit15, keep SCL=0, and go to SETUP; a word pushed into an empty FIFO SHALL raise CS on the 2nd clk edge after acceptance.
REQ-018 SETUP SHALL last DIV cycles and then enter SHIFT with SCL=1.
REQ-019 SHIFT SHALL produce 16 SCL pulses, each DIV cycles high followed by DIV cycles low.
REQ-020 On each of the first 15 SCL falling edges, MOSI SHALL advance to the next lower bit.
REQ-021 On the 16th SCL falling edge, CS SHALL go to 0 and MOSI SHALL go to 0.
REQ-022 TRAIL SHALL emit one further SCL pulse (DIV high, DIV low) with CS=0; this 17th rising edge is the downstream receiver's commit edge.
REQ-023 GAPW SHALL hold CS, SCL and MOSI at 0 for GAP cycles, then return to IDLE.
REQ-024 Frame timing: CS SHALL be high for exactly 32*DIV cycles, and a frame SHALL span 35*DIV+GAP cycles from CS rise to the end of GAPW.
REQ-025 Back-to-back words SHALL be sent with no extra idle beyond GAP plus one IDLE cycle.
REQ-026 The half-period counter SHALL be 8 bits and the bit counter 5 bits, with no wrap inside a frame.
REQ-027 in_valid and in_data SHALL NOT affect a frame already in progress.

Reset
REQ-028 While resetq=0: CS=0, SCL=0, MOSI=0, busy=0, in_ready=1, FIFO empty, state IDLE, all counters 0.
REQ-029 Reset assertion mid-frame SHALL abort the frame immediately (asynchronously) and discard all FIFO contents.
REQ-030 Transmission SHALL restart only after a new word is accepted following reset release.

Verification
REQ-031 DIV=2, push 0xA5C3 -> 17 SCL rises; MOSI at rises 1..16 = 1010010111000011; CS=1 at rises 1..16 and 0 at rise 17; a behavioural slave model latches 0xA5C3.
REQ-032 DIV=4, GAP=4, push 0x0001 -> CS high for 128 cycles; busy high for 144 cycles; CS rises on the 2nd edge after acceptance.
REQ-033 DEPTH=4, hold in_valid with words 1..6 while a long frame runs -> first word popped, next 4 accepted, in_ready low, word 6 held until a pop; all accepted words emitted in order.
REQ-034 FIFO full, pop and push on the same edge -> push rejected, occupancy drops by 1, in_ready rises the next cycle.
REQ-035 Assert resetq at the 8th SCL pulse with 3 words queued -> CS, SCL, MOSI and busy go low immediately, in_ready=1, no further pulses until a new push.
REQ-036 Push 0xFFFF then 0x0000 back-to-back -> the two frames are separated by exactly GAP+1 cycles of CS=0 after TRAIL, and the slave model latches 0xFFFF then 0x0000.

Source files
------------

// File: rtl/spi_word_tx.sv
// SPI-style word transmitter: a small input FIFO feeding a 16-bit MSB-first
// serialiser with an extra trailing SCL pulse and an idle gap between frames.
module spi_word_tx #(
    parameter int DIV   = 4,
    parameter int GAP   = 4,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        CS,
    output logic        SCL,
    output logic        MOSI,
    output logic        busy
);

    localparam int              AW     = $clog2(DEPTH);
    localparam logic [7:0]      DIV_M1 = 8'(DIV - 1);
    localparam logic [7:0]      GAP_M1 = 8'(GAP - 1);
    localparam logic [AW:0]     FULL   = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_TRAIL = 3'd3,
        S_GAPW  = 3'd4
    } state_t;

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    state_t        r_state;
    logic [7:0]    r_half;
    logic [4:0]    r_bit;
    logic [15:0]   r_shift;
    logic          r_cs;
    logic          r_scl;
    logic          r_busy;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;

    assign in_ready = (r_count != FULL);
    assign w_empty  = (r_count == {(AW + 1){1'b0}});
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_state == S_IDLE) && !w_empty;

    assign CS   = r_cs;
    assign SCL  = r_scl;
    assign MOSI = r_shift[15];
    assign busy = r_busy;

    // FIFO storage; contents are only meaningful where r_count says so
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {(AW + 1){1'b0}};
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame sequencer; MOSI is the shift register MSB, so shifting zeros in
    // leaves MOSI low once the 16th bit has been sent
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_state <= S_IDLE;
            r_half  <= 8'd0;
            r_bit   <= 5'd0;
            r_shift <= 16'h0000;
            r_cs    <= 1'b0;
            r_scl   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_shift <= r_mem[r_rptr];
                        r_cs    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_scl   <= 1'b0;
                        r_half  <= DIV_M1;
                        r_bit   <= 5'd0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_half == 8'd0) begin
                        r_scl   <= 1'b1;
                        r_half  <= DIV_M1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_half <= r_half - 8'd1;
                    end
                end
                S_SHIFT: begin
                    if (r_half != 8'd0) begin
                        r_half <= r_half - 8'd1;
                    end else begin
                        r_half  <= DIV_M1;
                        r_scl   <= !r_scl;
                        if (r_scl) begin
                            r_shift <= {r_shift[14:0], 1'b0};
                            r_bit   <= r_bit + 5'd1;
                            if (r_bit == 5'd15) begin
                                r_cs    <= 1'b0;
                                r_state <= S_TRAIL;
                            end
                        end
                    end
                end
                S_TRAIL: begin
                    // r_bit reaches 17 once the commit pulse has fallen
                    if (r_half != 8'd0) begin
                        r_half <= r_half - 8'd1;
                    end else if (r_scl) begin
                        r_scl  <= 1'b0;
                        r_bit  <= 5'd17;
                        r_half <= DIV_M1;
                    end else if (r_bit == 5'd17) begin
                        r_half  <= GAP_M1;
                        r_state <= S_GAPW;
                    end else begin
                        r_scl  <= 1'b1;
                        r_half <= DIV_M1;
                    end
                end
                S_GAPW: begin
                    if (r_half == 8'd0) begin
                        r_busy  <= 1'b0;
                        r_bit   <= 5'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_half <= r_half - 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_half  <= 8'd0;
                    r_bit   <= 5'd0;
                    r_shift <= 16'h0000;
                    r_cs    <= 1'b0;
                    r_scl   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_word_tx.sv
// Bench for spi_word_tx: a cycle-offset waveform model, a FIFO/pop-time model
// and a behavioural SPI slave that commits a word on the 17th SCL rise.
module tb_spi_word_tx;

    localparam int DIV    = 2;
    localparam int GAP    = 4;
    localparam int DEPTH  = 4;
    localparam int CS_LEN = 32 * DIV;
    localparam int FRAME  = 35 * DIV + GAP;

    logic        clk      = 1'b0;
    logic        resetq   = 1'b0;
    logic [15:0] in_data  = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        CS;
    logic        SCL;
    logic        MOSI;
    logic        busy;

    spi_word_tx #(.DIV(DIV), .GAP(GAP), .DEPTH(DEPTH)) u_dut (
        .clk      (clk),
        .resetq   (resetq),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .CS       (CS),
        .SCL      (SCL),
        .MOSI     (MOSI),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [15:0] m_q[$];
    logic [15:0] exp_tx[$];
    logic [15:0] got_q[$];
    int          m_next_pop = 0;
    int          m_last_pop = 0;
    int          m_off = 0;
    bit          m_active = 1'b0;
    bit          m_pop = 1'b0;
    bit          m_acc = 1'b0;
    bit          m_full_before = 1'b0;
    logic [15:0] m_word = 16'h0000;
    logic [4:0]  exp_wave = 5'b00001;

    // Behavioural slave: shifts MOSI on SCL rises while CS=1, commits on the next rise with CS=0
    int          s_nbits = 0;
    logic [15:0] s_sh = 16'h0000;
    logic        s_prev_scl = 1'b0;
    always @(negedge clk) begin
        if (!resetq) begin
            s_nbits    = 0;
            s_prev_scl = 1'b0;
        end else begin
            if (SCL && !s_prev_scl) begin
                if (CS) begin
                    s_sh    = {s_sh[14:0], MOSI};
                    s_nbits = s_nbits + 1;
                end else begin
                    if (s_nbits == 16) got_q.push_back(s_sh);
                    s_nbits = 0;
                end
            end
            s_prev_scl = SCL;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected {CS,SCL,MOSI,busy} o cycles after the frame's CS rise
    function automatic logic [3:0] wave_at(input bit act, input int o, input logic [15:0] w);
        logic       cs, scl, mosi, bsy;
        logic [3:0] idx;
        cs   = act && (o < CS_LEN);
        bsy  = act && (o < FRAME);
        scl  = act && (o >= DIV) && (o < 34 * DIV) && ((((o - DIV) / DIV) % 2) == 0);
        idx  = 4'(15 - o / (2 * DIV));
        mosi = cs ? w[idx] : 1'b0;
        return {cs, scl, mosi, bsy};
    endfunction

    function automatic bit model_busy();
        return (m_q.size() > 0) || (m_active && (m_off <= FRAME));
    endfunction

    task automatic model_clear();
        m_q.delete();
        exp_tx.delete();
        m_active   = 1'b0;
        m_next_pop = 0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, sample at the next negedge
    task automatic step(input logic v, input logic [15:0] d);
        bit rdy;
        bit pop;
        logic [15:0] w;
        in_valid = v;
        in_data  = d;
        rdy = (m_q.size() < DEPTH);
        pop = (m_q.size() > 0) && (cyc >= m_next_pop);
        m_pop = pop;
        m_acc = v && rdy;
        m_full_before = !rdy;
        if (pop) begin
            w = m_q.pop_front();
            exp_tx.push_back(w);
            m_word     = w;
            m_last_pop = cyc;
            m_active   = 1'b1;
            m_next_pop = cyc + FRAME + 1;
        end
        if (v && rdy) m_q.push_back(d);
        @(negedge clk);
        m_off = cyc - m_last_pop;
        cyc   = cyc + 1;
        exp_wave = {wave_at(m_active, m_off, m_word), (m_q.size() < DEPTH)};
    endtask

    task automatic test_reset();
        resetq = 1'b0;
        in_valid = 1'b0;
        model_clear();
        repeat (3) begin @(negedge clk); cyc = cyc + 1; end
        n_cmp++;
        if ({CS, SCL, MOSI, busy} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected 0000", {CS, SCL, MOSI, busy});
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 1", in_ready);
        end
        resetq = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 16'h0000);
            n_cmp++;
            if ({CS, SCL, MOSI, busy, in_ready} !== exp_wave) begin
                n_fail++; $display("FAIL idle_after_reset: got %b expected %b", {CS, SCL, MOSI, busy, in_ready}, exp_wave);
            end
        end
    endtask

    task automatic test_single(input logic [15:0] w);
        int          cs_n = 0;
        int          busy_n = 0;
        int          rises = 0;
        logic        prev_scl = 1'b0;
        logic [15:0] mosi_v = 16'h0000;
        logic [16:0] cs_v = 17'h00000;
        step(1'b1, w);
        n_cmp++;
        if (CS !== 1'b0) begin
            n_fail++; $display("FAIL cs_first_edge: got %b expected 0", CS);
        end
        step(1'b0, 16'h0000);
        n_cmp++;
        if (CS !== 1'b1) begin
            n_fail++; $display("FAIL cs_second_edge: got %b expected 1", CS);
        end
        for (int i = 0; i < FRAME + 6; i++) begin
            n_cmp++;
            if ({CS, SCL, MOSI, busy, in_ready} !== exp_wave) begin
                n_fail++; $display("FAIL single_wave @%0d: got %b expected %b", cyc, {CS, SCL, MOSI, busy, in_ready}, exp_wave);
            end
            if (CS) cs_n++;
            if (busy) busy_n++;
            if (SCL && !prev_scl) begin
                rises++;
                if (rises <= 16) mosi_v = {mosi_v[14:0], MOSI};
                cs_v = {cs_v[15:0], CS};
            end
            prev_scl = SCL;
            step(1'b0, 16'h0000);
        end
        n_cmp++;
        if (cs_n != CS_LEN) begin n_fail++; $display("FAIL cs_high_len: got %0d expected %0d", cs_n, CS_LEN); end
        n_cmp++;
        if (busy_n != FRAME) begin n_fail++; $display("FAIL busy_len: got %0d expected %0d", busy_n, FRAME); end
        n_cmp++;
        if (rises != 17) begin n_fail++; $display("FAIL scl_rises: got %0d expected 17", rises); end
        n_cmp++;
        if (mosi_v !== w) begin n_fail++; $display("FAIL mosi_at_rises: got %h expected %h", mosi_v, w); end
        n_cmp++;
        if (cs_v !== 17'h1FFFE) begin n_fail++; $display("FAIL cs_at_rises: got %b expected %b", cs_v, 17'h1FFFE); end
        n_cmp++;
        if (got_q.size() != 1 || got_q[0] !== w) begin
            n_fail++; $display("FAIL slave_word: got %0d words first %h expected %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'hxxxx, w);
        end
        got_q.delete();
        exp_tx.delete();
    endtask

    task automatic test_fifo_full();
        int  k = 1;
        int  guard = 0;
        int  n_fullpop = 0;
        bit  saw_full = 1'b0;
        while ((k <= 6 || model_busy()) && guard < 3000) begin
            n_cmp++;
            if ({CS, SCL, MOSI, busy, in_ready} !== exp_wave) begin
                n_fail++; $display("FAIL fifo_wave @%0d: got %b expected %b", cyc, {CS, SCL, MOSI, busy, in_ready}, exp_wave);
            end
            if (k == 6 && !in_ready) saw_full = 1'b1;
            step(k <= 6, 16'(k));
            if (m_acc) k++;
            if (m_pop && m_full_before && in_valid) begin
                n_fullpop++;
                n_cmp++;
                if (in_ready !== 1'b1) begin
                    n_fail++; $display("FAIL full_pop_ready: got %b expected 1", in_ready);
                end
            end
            guard++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (guard >= 3000) begin n_fail++; $display("FAIL fifo_timeout: got %0d cycles expected under 3000", guard); end
        n_cmp++;
        if (!saw_full) begin n_fail++; $display("FAIL fifo_full_seen: got 0 expected 1"); end
        n_cmp++;
        if (n_fullpop == 0) begin n_fail++; $display("FAIL full_pop_event: got 0 expected at least 1"); end
        n_cmp++;
        if (got_q.size() != 6) begin n_fail++; $display("FAIL fifo_count: got %0d expected 6", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 6; i++) begin
            n_cmp++;
            if (got_q[i] !== 16'(i + 1)) begin
                n_fail++; $display("FAIL fifo_order[%0d]: got %h expected %h", i, got_q[i], 16'(i + 1));
            end
        end
        got_q.delete();
        exp_tx.delete();
    endtask

    task automatic test_back_to_back();
        int   guard = 0;
        int   fall_cyc = -1;
        int   gap = -1;
        logic prev_cs = 1'b0;
        step(1'b1, 16'hFFFF);
        step(1'b1, 16'h0000);
        while (model_busy() && guard < 1000) begin
            n_cmp++;
            if ({CS, SCL, MOSI, busy, in_ready} !== exp_wave) begin
                n_fail++; $display("FAIL b2b_wave @%0d: got %b expected %b", cyc, {CS, SCL, MOSI, busy, in_ready}, exp_wave);
            end
            if (prev_cs && !CS) fall_cyc = cyc;
            if (!prev_cs && CS && fall_cyc >= 0 && gap < 0) gap = cyc - fall_cyc;
            prev_cs = CS;
            step(1'b0, 16'h0000);
            guard++;
        end
        n_cmp++;
        if (guard >= 1000) begin n_fail++; $display("FAIL b2b_timeout: got %0d cycles expected under 1000", guard); end
        // CS-low run = last low half-pulse + TRAIL pulse (3*DIV) + GAP + one IDLE cycle
        n_cmp++;
        if (gap != 3 * DIV + GAP + 1) begin n_fail++; $display("FAIL b2b_gap: got %0d expected %0d", gap, 3 * DIV + GAP + 1); end
        n_cmp++;
        if (got_q.size() != 2 || got_q[0] !== 16'hFFFF || got_q[1] !== 16'h0000) begin
            n_fail++; $display("FAIL b2b_words: got %0d words expected FFFF then 0000", got_q.size());
        end
        got_q.delete();
        exp_tx.delete();
    endtask

    task automatic test_reset_abort();
        int guard = 0;
        int rises = 0;
        logic prev_scl = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 16'($urandom));
        while (!(m_active && m_off == 15 * DIV) && guard < 200) begin
            n_cmp++;
            if ({CS, SCL, MOSI, busy, in_ready} !== exp_wave) begin
                n_fail++; $display("FAIL abort_wave @%0d: got %b expected %b", cyc, {CS, SCL, MOSI, busy, in_ready}, exp_wave);
            end
            step(1'b0, 16'h0000);
            guard++;
        end
        n_cmp++;
        if (SCL !== 1'b1 || CS !== 1'b1) begin
            n_fail++; $display("FAIL abort_8th_pulse: got CS=%b SCL=%b expected 1 1", CS, SCL);
        end
        #1;
        resetq = 1'b0;
        #1;
        n_cmp++;
        if ({CS, SCL, MOSI, busy, in_ready} !== 5'b00001) begin
            n_fail++; $display("FAIL abort_immediate: got %b expected 00001", {CS, SCL, MOSI, busy, in_ready});
        end
        n_cmp++;
        if (got_q.size() != 0) begin n_fail++; $display("FAIL abort_no_commit: got %0d expected 0", got_q.size()); end
        model_clear();
        got_q.delete();
        repeat (2) begin @(negedge clk); cyc = cyc + 1; end
        resetq = 1'b1;
        exp_wave = 5'b00001;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step(1'b0, 16'h0000);
            n_cmp++;
            if ({CS, SCL, MOSI, busy, in_ready} !== exp_wave) begin
                n_fail++; $display("FAIL post_abort_idle @%0d: got %b expected %b", cyc, {CS, SCL, MOSI, busy, in_ready}, exp_wave);
            end
            if (SCL && !prev_scl) rises++;
            prev_scl = SCL;
        end
        n_cmp++;
        if (rises != 0) begin n_fail++; $display("FAIL post_abort_pulses: got %0d expected 0", rises); end
        test_single(16'($urandom));
    endtask

    task automatic test_random();
        int guard = 0;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, 16'($urandom));
            n_cmp++;
            if ({CS, SCL, MOSI, busy, in_ready} !== exp_wave) begin
                n_fail++; $display("FAIL rand_wave @%0d: got %b expected %b", cyc, {CS, SCL, MOSI, busy, in_ready}, exp_wave);
            end
        end
        while (model_busy() && guard < 3000) begin
            step(1'b0, 16'h0000);
            n_cmp++;
            if ({CS, SCL, MOSI, busy, in_ready} !== exp_wave) begin
                n_fail++; $display("FAIL rand_drain_wave @%0d: got %b expected %b", cyc, {CS, SCL, MOSI, busy, in_ready}, exp_wave);
            end
            guard++;
        end
        n_cmp++;
        if (guard >= 3000) begin n_fail++; $display("FAIL rand_timeout: got %0d cycles expected under 3000", guard); end
        n_cmp++;
        if (got_q.size() != exp_tx.size()) begin
            n_fail++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_tx.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_tx.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_tx[i]) begin
                n_fail++; $display("FAIL rand_word[%0d]: got %h expected %h", i, got_q[i], exp_tx[i]);
            end
        end
        got_q.delete();
        exp_tx.delete();
    endtask

    initial begin
        test_reset();
        test_single(16'hA5C3);
        test_single(16'h0001);
        test_single(16'($urandom));
        test_fifo_full();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
